// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared definitions for the instruction-fetch stage: FSM state
//             encoding, default widths, the IF/ID pipeline record and its
//             bubble value, and the PC increment.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int FETCH_PC_W   = 8;    // byte address width
    localparam int FETCH_INST_W = 16;   // instruction width (two bytes)
    localparam int FETCH_CNT_W  = 16;   // fetched-instruction counter width

    // Every instruction is two bytes, so the PC always advances by 2.
    localparam logic [FETCH_PC_W-1:0] PC_INC = 8'd2;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // IF/ID pipeline record handed to decode.
    typedef struct packed {
        logic                    valid;
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_PC_W-1:0]   pc_next;
    } ifid_t;

    // A bubble carries no instruction; all fields are driven to zero so
    // downstream logic never sees stale addresses.
    localparam ifid_t IFID_BUBBLE = '{
        valid:   1'b0,
        inst:    '0,
        pc:      '0,
        pc_next: '0
    };

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Bundles the fetch stage's memory, decode-control and IF/ID
//             signals.
//             master : the fetch stage (drives pc_o, IF/ID, status outputs)
//             slave  : memory/decode side (drives inst_i and control inputs)
//  Signals  : pc_o, inst_i, stall_i, redirect_i, redirect_pc_i, halt_i,
//             ifid_valid_o, ifid_inst_o, ifid_pc_o, ifid_pc_next_o,
//             misalign_o, halted_o, fetch_count_o
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = FETCH_PC_W,
    parameter int INST_W = FETCH_INST_W,
    parameter int CNT_W  = FETCH_CNT_W
);

    logic [PC_W-1:0]   pc_o;
    logic [INST_W-1:0] inst_i;
    logic              stall_i;
    logic              redirect_i;
    logic [PC_W-1:0]   redirect_pc_i;
    logic              halt_i;
    logic              ifid_valid_o;
    logic [INST_W-1:0] ifid_inst_o;
    logic [PC_W-1:0]   ifid_pc_o;
    logic [PC_W-1:0]   ifid_pc_next_o;
    logic              misalign_o;
    logic              halted_o;
    logic [CNT_W-1:0]  fetch_count_o;

    modport master (
        output pc_o,
        input  inst_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  halt_i,
        output ifid_valid_o,
        output ifid_inst_o,
        output ifid_pc_o,
        output ifid_pc_next_o,
        output misalign_o,
        output halted_o,
        output fetch_count_o
    );

    modport slave (
        input  pc_o,
        output inst_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        output halt_i,
        input  ifid_valid_o,
        input  ifid_inst_o,
        input  ifid_pc_o,
        input  ifid_pc_next_o,
        input  misalign_o,
        input  halted_o,
        input  fetch_count_o
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_ifid.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_ifid
//  Purpose  : IF/ID pipeline register. Flush has priority over load; with
//             neither asserted the register holds its contents.
//  Ports    : clk   - clock
//             rst   - synchronous active-high reset (loads bubble)
//             load  - capture d
//             flush - replace contents with a bubble
//             d     - incoming IF/ID record
//             q     - registered IF/ID record
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage_ifid
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= IFID_BUBBLE;
        end else if (flush) begin
            r_q <= IFID_BUBBLE;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : fetch_stage_ifid
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the program counter, addresses
//             the instruction memory, captures the returned big-endian word
//             into the IF/ID register, and handles stall, redirect/flush,
//             halt and a fetched-instruction counter.
//  Ports    : clk - clock
//             rst - synchronous active-high reset
//             bus - fetch_stage_if.master (memory, control, IF/ID, status)
//  Notes    : PC_W and INST_W must match the widths of the IF/ID record in
//             fetch_stage_pkg. RESET_PC must be even.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = FETCH_PC_W,
    parameter int              INST_W   = FETCH_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = FETCH_CNT_W
)(
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.master  bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [PC_W-1:0]   w_pc_plus;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_misalign;

    logic              w_ifid_load;
    logic              w_ifid_flush;
    logic              w_cnt_inc;
    logic              w_misalign_next;
    ifid_t             w_ifid_d;
    ifid_t             w_ifid_q;

    // Modulo-2^PC_W increment: 0xFE wraps to 0x00 naturally.
    assign w_pc_plus = r_pc + PC_W'(PC_INC);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle controls.
    // In RUN the priority is redirect > halt > stall > normal fetch.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ifid_load     = 1'b0;
        w_ifid_flush    = 1'b0;
        w_cnt_inc       = 1'b0;
        w_misalign_next = 1'b0;

        case (r_state)
            ST_BOOT: begin
                // One idle cycle after reset so memory sees a stable address.
                w_state_next = ST_RUN;
                w_ifid_flush = 1'b1;
            end

            ST_RUN: begin
                if (bus.redirect_i) begin
                    // Force the target even; the odd bit is reported instead.
                    w_pc_next       = {bus.redirect_pc_i[PC_W-1:1], 1'b0};
                    w_ifid_flush    = 1'b1;
                    w_misalign_next = bus.redirect_pc_i[0];
                end else if (bus.halt_i) begin
                    w_ifid_flush = 1'b1;
                    w_state_next = ST_HALTED;
                end else if (!bus.stall_i) begin
                    w_ifid_load = 1'b1;
                    w_pc_next   = w_pc_plus;
                    w_cnt_inc   = 1'b1;
                end
            end

            ST_HALTED: begin
                // Everything frozen until reset.
            end

            default: begin
                w_state_next = ST_BOOT;
                w_ifid_flush = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, counter and misalign pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_cnt      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    always_comb begin
        w_ifid_d         = IFID_BUBBLE;
        w_ifid_d.valid   = 1'b1;
        w_ifid_d.inst    = bus.inst_i;
        w_ifid_d.pc      = r_pc;
        w_ifid_d.pc_next = w_pc_plus;
    end

    fetch_stage_ifid u_ifid (
        .clk   (clk),
        .rst   (rst),
        .load  (w_ifid_load),
        .flush (w_ifid_flush),
        .d     (w_ifid_d),
        .q     (w_ifid_q)
    );

    // ------------------------------------------------------------------
    // Outputs (all sourced from registers)
    // ------------------------------------------------------------------
    assign bus.pc_o           = r_pc;
    assign bus.ifid_valid_o   = w_ifid_q.valid;
    assign bus.ifid_inst_o    = w_ifid_q.inst;
    assign bus.ifid_pc_o      = w_ifid_q.pc;
    assign bus.ifid_pc_next_o = w_ifid_q.pc_next;
    assign bus.misalign_o     = r_misalign;
    assign bus.halted_o       = (r_state == ST_HALTED);
    assign bus.fetch_count_o  = r_cnt;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A behavioural model tracks
//             the expected outputs every cycle; directed vectors add literal
//             expectations at key points.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instruction memory (256 bytes, big-endian words)
    // ------------------------------------------------------------------
    logic [7:0] mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h04] = 8'h70; mem[8'h05] = 8'h00;
        mem[8'h06] = 8'hE0; mem[8'h07] = 8'hFF;
        mem[8'h10] = 8'h55; mem[8'h11] = 8'h66;
        mem[8'h20] = 8'hAB; mem[8'h21] = 8'hCD;
        mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34;
    end

    logic [7:0] w_pc_hi;
    assign w_pc_hi    = bus.pc_o + 8'd1;
    assign bus.inst_i = {mem[bus.pc_o], mem[w_pc_hi]};

    // ------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 = post-reset idle cycle, 1 = fetching,
    // 2 = halted.
    // ------------------------------------------------------------------
    int          m_phase = 0;
    logic [7:0]  m_pc    = 8'h00;
    logic        m_valid = 1'b0;
    logic [15:0] m_inst  = 16'h0;
    logic [7:0]  m_ipc   = 8'h00;
    logic [7:0]  m_inext = 8'h00;
    logic        m_mis   = 1'b0;
    logic [15:0] m_cnt   = 16'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_pc    <= 8'h00;
            m_valid <= 1'b0; m_inst <= 16'h0; m_ipc <= 8'h00; m_inext <= 8'h00;
            m_mis   <= 1'b0;
            m_cnt   <= 16'h0;
        end else begin
            m_mis <= 1'b0;
            if (m_phase == 0) begin
                m_phase <= 1;
                m_valid <= 1'b0; m_inst <= 16'h0; m_ipc <= 8'h00; m_inext <= 8'h00;
            end else if (m_phase == 1) begin
                if (bus.redirect_i) begin
                    m_pc    <= bus.redirect_pc_i & 8'hFE;
                    m_mis   <= bus.redirect_pc_i[0];
                    m_valid <= 1'b0; m_inst <= 16'h0; m_ipc <= 8'h00; m_inext <= 8'h00;
                end else if (bus.halt_i) begin
                    m_phase <= 2;
                    m_valid <= 1'b0; m_inst <= 16'h0; m_ipc <= 8'h00; m_inext <= 8'h00;
                end else if (!bus.stall_i) begin
                    m_valid <= 1'b1;
                    m_inst  <= {mem[m_pc], mem[8'(m_pc + 8'd1)]};
                    m_ipc   <= m_pc;
                    m_inext <= 8'(m_pc + 8'd2);
                    m_pc    <= 8'(m_pc + 8'd2);
                    m_cnt   <= m_cnt + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model pc_o",           32'(bus.pc_o),           32'(m_pc));
            cmp("model ifid_valid_o",   32'(bus.ifid_valid_o),   32'(m_valid));
            cmp("model ifid_inst_o",    32'(bus.ifid_inst_o),    32'(m_inst));
            cmp("model ifid_pc_o",      32'(bus.ifid_pc_o),      32'(m_ipc));
            cmp("model ifid_pc_next_o", 32'(bus.ifid_pc_next_o), 32'(m_inext));
            cmp("model misalign_o",     32'(bus.misalign_o),     32'(m_mis));
            cmp("model halted_o",       32'(bus.halted_o),       32'(m_phase == 2));
            cmp("model fetch_count_o",  32'(bus.fetch_count_o),  32'(m_cnt));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string name, input logic valid,
                            input logic [15:0] inst, input logic [7:0] pc);
        cmp({name, " valid"}, 32'(bus.ifid_valid_o), 32'(valid));
        cmp({name, " inst"},  32'(bus.ifid_inst_o),  32'(inst));
        cmp({name, " pc"},    32'(bus.ifid_pc_o),    32'(pc));
    endtask

    initial begin
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 8'h00;
        bus.halt_i        = 1'b0;

        // Reset values
        tick();
        chk_en = 1'b1;
        tick();
        cmp("rst pc_o", 32'(bus.pc_o), 32'h00);
        chk_ifid("rst ifid", 1'b0, 16'h0000, 8'h00);
        cmp("rst pc_next", 32'(bus.ifid_pc_next_o), 32'h00);
        cmp("rst misalign", 32'(bus.misalign_o), 32'h0);
        cmp("rst halted", 32'(bus.halted_o), 32'h0);
        cmp("rst count", 32'(bus.fetch_count_o), 32'h0);

        // Boot cycle, then four fetches
        rst = 1'b0;
        tick();
        cmp("boot valid", 32'(bus.ifid_valid_o), 32'h0);
        cmp("boot pc_o", 32'(bus.pc_o), 32'h00);
        tick();
        chk_ifid("fetch0", 1'b1, 16'h0000, 8'h00);
        tick();
        chk_ifid("fetch2", 1'b1, 16'h0000, 8'h02);
        tick();
        chk_ifid("fetch4", 1'b1, 16'h7000, 8'h04);
        cmp("fetch4 pc_o", 32'(bus.pc_o), 32'h06);

        // Stall three cycles
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall", 1'b1, 16'h7000, 8'h04);
            cmp("stall pc_o", 32'(bus.pc_o), 32'h06);
            cmp("stall count", 32'(bus.fetch_count_o), 32'd3);
        end
        bus.stall_i = 1'b0;
        tick();
        chk_ifid("fetch6", 1'b1, 16'hE0FF, 8'h06);
        cmp("fetch6 count", 32'(bus.fetch_count_o), 32'd4);

        // Misaligned redirect during stall
        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'h21;
        tick();
        cmp("redir pc_o", 32'(bus.pc_o), 32'h20);
        cmp("redir valid", 32'(bus.ifid_valid_o), 32'h0);
        cmp("redir misalign", 32'(bus.misalign_o), 32'h1);
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        tick();
        chk_ifid("redir target", 1'b1, 16'hABCD, 8'h20);
        cmp("misalign pulse end", 32'(bus.misalign_o), 32'h0);

        // PC wrap at 0xFE
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'hFE;
        tick();
        cmp("wrap redir pc_o", 32'(bus.pc_o), 32'hFE);
        bus.redirect_i = 1'b0;
        tick();
        chk_ifid("wrap FE", 1'b1, 16'h1234, 8'hFE);
        cmp("wrap pc_next", 32'(bus.ifid_pc_next_o), 32'h00);
        cmp("wrap pc_o", 32'(bus.pc_o), 32'h00);
        tick();
        cmp("wrap ifid 00", 32'(bus.ifid_pc_o), 32'h00);
        tick();
        cmp("wrap ifid 02", 32'(bus.ifid_pc_o), 32'h02);
        cmp("wrap count", 32'(bus.fetch_count_o), 32'd8);

        // Halt with simultaneous stall
        bus.halt_i  = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        cmp("halt halted", 32'(bus.halted_o), 32'h1);
        cmp("halt valid", 32'(bus.ifid_valid_o), 32'h0);
        cmp("halt pc_o", 32'(bus.pc_o), 32'h04);
        bus.halt_i        = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'h10;
        tick();
        cmp("halted redir ignored", 32'(bus.pc_o), 32'h04);
        bus.redirect_i = 1'b0;
        tick();
        tick();
        cmp("still halted", 32'(bus.halted_o), 32'h1);
        cmp("halted count", 32'(bus.fetch_count_o), 32'd8);

        // Reset out of HALTED
        rst = 1'b1;
        tick();
        cmp("rst2 pc_o", 32'(bus.pc_o), 32'h00);
        cmp("rst2 halted", 32'(bus.halted_o), 32'h0);
        cmp("rst2 count", 32'(bus.fetch_count_o), 32'h0);
        rst = 1'b0;
        tick();
        cmp("boot2 valid", 32'(bus.ifid_valid_o), 32'h0);
        tick();
        chk_ifid("boot2 fetch0", 1'b1, 16'h0000, 8'h00);
        tick();
        tick();
        chk_ifid("boot2 fetch4", 1'b1, 16'h7000, 8'h04);

        // Reset coincident with redirect and halt
        rst               = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'h41;
        bus.halt_i        = 1'b1;
        tick();
        cmp("rst+redir pc_o", 32'(bus.pc_o), 32'h00);
        cmp("rst+redir valid", 32'(bus.ifid_valid_o), 32'h0);
        cmp("rst+redir misalign", 32'(bus.misalign_o), 32'h0);
        cmp("rst+redir halted", 32'(bus.halted_o), 32'h0);
        cmp("rst+redir count", 32'(bus.fetch_count_o), 32'h0);
        rst            = 1'b0;
        bus.redirect_i = 1'b0;
        bus.halt_i     = 1'b0;
        tick();
        cmp("boot3 valid", 32'(bus.ifid_valid_o), 32'h0);
        tick();
        chk_ifid("boot3 fetch0", 1'b1, 16'h0000, 8'h00);
        cmp("boot3 count", 32'(bus.fetch_count_o), 32'd1);
        tick();
        tick();

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
